// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and helpers for the instruction fetch sequencer
package fetch_pkg;

  localparam int PC_W_DEF = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  // Callers pass a sign-extended offset and truncate the result to PC width,
  // so the wrap-around falls out of the truncation.
  function automatic logic [31:0] pc_rel(input logic [31:0] pc, input logic [31:0] off);
    return pc + off;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - return-address LIFO; only the pointer is reset, contents are not
module ret_stack #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] top_idx;
  logic [AW-1:0] wr_idx;

  assign empty   = (ptr_q == '0);
  assign full    = (ptr_q == PW'(DEPTH));
  assign top_idx = AW'(ptr_q - PW'(1));
  assign wr_idx  = AW'(ptr_q);
  assign rdata   = empty ? '0 : mem_q[top_idx];

  always_comb begin
    ptr_d = ptr_q;
    if (clr)
      ptr_d = '0;
    else if (push && !full)
      ptr_d = ptr_q + PW'(1);
    else if (pop && !empty)
      ptr_d = ptr_q - PW'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset)
      ptr_q <= '0;
    else
      ptr_q <= ptr_d;
  end

  always_ff @(posedge Clk) begin
    if (!Reset && !clr && push && !full)
      mem_q[wr_idx] <= wdata;
  end

endmodule

// File: rtl/inst_fetch_seq.sv
// rtl/inst_fetch_seq.sv - program counter sequencer with branches, call/return and halt
module inst_fetch_seq
  import fetch_pkg::*;
#(
  parameter int                      PC_W      = PC_W_DEF,
  parameter int                      OFF_W     = 8,
  parameter int                      NUM_PROGS = 3,
  parameter logic [NUM_PROGS*PC_W-1:0] PROG_BASE = '0,
  parameter int                      RAS_DEPTH = 4
) (
  input  logic                                              Clk,
  input  logic                                              Reset,
  input  logic                                              Start,
  input  logic [((NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1)-1:0] ProgSel,
  input  logic                                              Stall,
  input  logic                                              BranchEn,
  input  logic                                              BranchRel,
  input  logic [PC_W-1:0]                                   Target,
  input  logic [OFF_W-1:0]                                  Offset,
  input  logic                                              CallEn,
  input  logic                                              RetEn,
  input  logic                                              HaltReq,
  output logic [PC_W-1:0]                                   ProgCtr,
  output logic                                              Running,
  output logic                                              Done,
  output logic                                              ErrOvf,
  output logic                                              ErrUnf
);

  localparam int PS_W = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic            stk_push, stk_pop, stk_clr, stk_full, stk_empty;
  logic [PC_W-1:0] stk_rdata;
  logic [PC_W-1:0] pc_inc, pc_off, base_pc;

  assign pc_inc = pc_q + PC_W'(1);
  assign pc_off = PC_W'(pc_rel(32'(pc_q), 32'(signed'(Offset))));

  // Out-of-range selections fall back to entry 0.
  always_comb begin
    base_pc = PROG_BASE[0 +: PC_W];
    for (int i = 1; i < NUM_PROGS; i++) begin
      if (ProgSel == PS_W'(i))
        base_pc = PROG_BASE[i*PC_W +: PC_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_clr  = 1'b0;
    if (Start) begin
      state_d = ARMED;
      pc_d    = base_pc;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      stk_clr = 1'b1;
    end else begin
      case (state_q)
        ARMED: state_d = RUN;
        RUN: begin
          if (Stall) begin
            state_d = RUN;
          end else if (HaltReq) begin
            state_d = HALT;
          end else if (RetEn) begin
            if (stk_empty) begin
              unf_d   = 1'b1;
              state_d = HALT;
            end else begin
              stk_pop = 1'b1;
              pc_d    = stk_rdata;
            end
          end else if (CallEn) begin
            if (stk_full) begin
              ovf_d   = 1'b1;
              state_d = HALT;
            end else begin
              stk_push = 1'b1;
              pc_d     = Target;
            end
          end else if (BranchEn) begin
            pc_d = BranchRel ? pc_off : Target;
          end else begin
            pc_d = pc_inc;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  ret_stack #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ret_stack (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (stk_clr),
    .push  (stk_push),
    .pop   (stk_pop),
    .wdata (pc_inc),
    .rdata (stk_rdata),
    .full  (stk_full),
    .empty (stk_empty)
  );

  assign ProgCtr = pc_q;
  assign Running = (state_q == RUN);
  assign Done    = (state_q == HALT);
  assign ErrOvf  = ovf_q;
  assign ErrUnf  = unf_q;

endmodule
